// File: rtl/wrr_pkg.sv
// Shared types and constants for the weighted round-robin arbiter.
package wrr_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RELOAD = 2'd1,
    GRANT  = 2'd2
  } wrr_state_e;

  localparam int WRR_DEF_WGT = 1;
endpackage

// File: rtl/wrr_rr_pick.sv
// Cyclic first-set picker starting at ptr: rotate right, isolate, rotate left.
module wrr_rr_pick #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);
  logic [N-1:0] w_rot;
  logic [N-1:0] w_iso;

  assign w_rot = N'({req, req} >> ptr);
  assign w_iso = w_rot & (~w_rot + 1'b1);
  assign gnt   = N'(({w_iso, w_iso} << ptr) >> N);

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end
endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with per-requester credits.
// Optional grant-hold timeout enabled by defining WRR_ARB_TIMEOUT_EN.
module wrr_arbiter
  import wrr_pkg::*;
#(
  parameter int N       = 8,
  parameter int WW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [N-1:0]         i_req,
  input  logic                 i_done,
  input  logic                 i_wgt_wr,
  input  logic [$clog2(N)-1:0] i_wgt_idx,
  input  logic [WW-1:0]        i_wgt_data,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_idx,
  output logic                 o_timeout
);
  localparam int PW = $clog2(N);

  wrr_state_e    r_state, w_state_n;
  logic [N-1:0]  r_gnt, w_gnt_n;
  logic [PW-1:0] r_idx, w_idx_n;
  logic [PW-1:0] r_ptr, w_ptr_n, w_nxt_ptr;
  logic [WW-1:0] r_wgt [N];
  logic [WW-1:0] r_crd [N];
  logic          r_to, w_to_n;
  logic [N-1:0]  w_elig, w_reld;
  logic [N-1:0]  w_pk_req, w_pk_gnt;
  logic [PW-1:0] w_pk_ptr, w_pk_idx;
  logic [WW-1:0] w_cur, w_dec;
  logic          w_hold, w_to_hit;
  logic          w_dec_en, w_clr, w_reload;

  always_comb begin
    w_reld = '0;
    w_elig = '0;
    for (int i = 0; i < N; i++) begin
      w_reld[i] = i_req[i] && (r_wgt[i] != '0);
      w_elig[i] = w_reld[i] && (r_crd[i] != '0);
    end
  end

  assign w_cur     = r_crd[r_idx];
  assign w_dec     = (w_cur == '0) ? '0 : w_cur - 1'b1;
  assign w_hold    = i_req[r_idx] && (w_dec != '0);
  assign w_nxt_ptr = (r_idx == PW'(N - 1)) ? '0 : r_idx + 1'b1;

  // In GRANT the picker looks ahead past the current winner.
  assign w_pk_req = (r_state == GRANT) ? (w_elig & ~r_gnt) : w_elig;
  assign w_pk_ptr = (r_state == GRANT) ? w_nxt_ptr : r_ptr;

  wrr_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req     (w_pk_req),
    .ptr     (w_pk_ptr),
    .gnt     (w_pk_gnt),
    .gnt_idx (w_pk_idx)
  );

`ifdef WRR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] r_hold;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      r_hold <= '0;
    else if (r_state == GRANT && !i_done)
      r_hold <= r_hold + 1'b1;
    else
      r_hold <= '0;
  end

  assign w_to_hit = (r_state == GRANT) && !i_done &&
                    (r_hold == TW'(TIMEOUT - 1));
`else
  // No hold counter: a grant is never revoked.
  assign w_to_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: begin
        if (|w_elig)      w_state_n = GRANT;
        else if (|w_reld) w_state_n = RELOAD;
      end
      RELOAD: w_state_n = IDLE;
      GRANT: begin
        if (w_to_hit) begin
          w_state_n = IDLE;
        end else if (i_done && !w_hold) begin
          if (|w_pk_gnt)    w_state_n = GRANT;
          else if (|w_reld) w_state_n = RELOAD;
          else              w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_n  = r_gnt;
    w_idx_n  = r_idx;
    w_ptr_n  = r_ptr;
    w_to_n   = 1'b0;
    w_dec_en = 1'b0;
    w_clr    = 1'b0;
    w_reload = (r_state == RELOAD);
    unique case (r_state)
      IDLE: begin
        w_gnt_n = w_pk_gnt;
        w_idx_n = w_pk_idx;
      end
      GRANT: begin
        if (w_to_hit) begin
          w_gnt_n = '0;
          w_idx_n = '0;
          w_ptr_n = w_nxt_ptr;
          w_to_n  = 1'b1;
          w_clr   = 1'b1;
        end else if (i_done) begin
          w_dec_en = 1'b1;
          if (!w_hold) begin
            w_ptr_n = w_nxt_ptr;
            w_gnt_n = w_pk_gnt;
            w_idx_n = w_pk_idx;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_gnt <= '0;
      r_idx <= '0;
      r_ptr <= '0;
      r_to  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_wgt[i] <= WW'(WRR_DEF_WGT);
        r_crd[i] <= '0;
      end
    end else begin
      r_gnt <= w_gnt_n;
      r_idx <= w_idx_n;
      r_ptr <= w_ptr_n;
      r_to  <= w_to_n;
      for (int i = 0; i < N; i++) begin
        if (i_wgt_wr && i_wgt_idx == PW'(i))
          r_wgt[i] <= i_wgt_data;
        if (w_reload) begin
          r_crd[i] <= r_wgt[i];
        end else if (r_idx == PW'(i)) begin
          if (w_clr)         r_crd[i] <= '0;
          else if (w_dec_en) r_crd[i] <= w_dec;
        end
      end
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_idx = r_idx;
  assign o_timeout = r_to;
endmodule
